i2c_cond_gen: RTL

I2C_COND_GEN -- requirements
Module: i2c_cond_gen

---
 rtl/i2c_cond_gen_pkg.sv | 61 ++++++
 rtl/i2c_cond_gen_period_timer.sv | 38 +++
 rtl/i2c_cond_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_cond_gen_pkg.sv
// Shared definitions for the I2C START/STOP condition generator.
//   - state_t        : condition-generator states
//   - CMD_*          : command codes on the cmd port
//   - *_TENTHS       : bus timing minimums in tenths of a microsecond
//   - t_cycles()     : converts a tenths-of-us minimum into clk cycles
//   - oe_of()        : line drive pattern {scl_oe, sda_oe} held in each state
package i2c_cond_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STA_SU,
        ST_STA_HD,
        ST_HOLD,
        ST_RS_LOW,
        ST_STO_LOW,
        ST_STO_SU,
        ST_STO_BUF
    } state_t;

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    // Standard mode (100 kHz) minimums, tenths of a microsecond.
    localparam int STD_SU_STA_TENTHS = 47;
    localparam int STD_HD_STA_TENTHS = 40;
    localparam int STD_SU_STO_TENTHS = 40;
    localparam int STD_BUF_TENTHS    = 47;
    localparam int STD_LOW_TENTHS    = 47;

    // Fast mode (400 kHz) minimums, tenths of a microsecond.
    localparam int FST_SU_STA_TENTHS = 6;
    localparam int FST_HD_STA_TENTHS = 6;
    localparam int FST_SU_STO_TENTHS = 6;
    localparam int FST_BUF_TENTHS    = 13;
    localparam int FST_LOW_TENTHS    = 13;

    // ceil(tenths/10 * us) in integer arithmetic; a zero result becomes 1 so
    // every timed state lasts at least one enabled cycle.
    function automatic int t_cycles(input int tenths, input int us);
        int c;
        c = (tenths * us + 9) / 10;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // {scl_oe, sda_oe}; a 1 pulls the line low.
    function automatic logic [1:0] oe_of(input state_t s);
        case (s)
            ST_STA_HD:  return 2'b01;
            ST_HOLD:    return 2'b11;
            ST_RS_LOW:  return 2'b10;
            ST_STO_LOW: return 2'b11;
            ST_STO_SU:  return 2'b01;
            default:    return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/i2c_cond_gen_period_timer.sv
// Down-counter that times the dwell of one condition-generator state.
//   clk, rst  : clock, asynchronous active-high reset (count cleared)
//   load      : high on the first cycle of a timed state; load_val is used
//               as the count for that cycle
//   load_val  : T-1 for the state being entered
//   enable    : count this cycle (low pauses the count)
//   expired   : count is 0 on an enabled cycle; the owner leaves the state
//               at the next edge, giving exactly T enabled cycles of dwell
module i2c_period_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;
    logic [W-1:0] cur;

    // The load value takes effect on the entry cycle itself, so that cycle
    // already counts as the first enabled cycle.
    assign cur     = load ? load_val : count;
    assign expired = enable && (cur == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (enable && (cur != '0)) begin
            count <= cur - W'(1);
        end else begin
            count <= cur;
        end
    end

endmodule

// File: rtl/i2c_cond_gen.sv
// I2C START / repeated-START / STOP condition generator.
//   US, I2C_MODE    : clk cycles per microsecond; 0 standard, 1 fast mode
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_vld, cmd    : command handshake; 01 START, 10 STOP, 00/11 no-op
//   cmd_rdy         : high in IDLE or HOLD (command can be taken)
//   bby             : bus busy from the bus-busy detector
//   scl_in, sda_in  : synchronized bus levels
//   scl_oe, sda_oe  : 1 pulls the line low, 0 releases it
//   done            : one-cycle pulse when a command completes
//   arbl            : one-cycle pulse on arbitration loss
//   own             : high whenever the block is out of IDLE
module i2c_cond_gen
    import i2c_cond_gen_pkg::*;
#(
    parameter int US       = 10,
    parameter int I2C_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_vld,
    input  logic [1:0] cmd,
    output logic       cmd_rdy,
    input  logic       bby,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       done,
    output logic       arbl,
    output logic       own
);

    localparam int T_SU_STA = t_cycles((I2C_MODE != 0) ? FST_SU_STA_TENTHS : STD_SU_STA_TENTHS, US);
    localparam int T_HD_STA = t_cycles((I2C_MODE != 0) ? FST_HD_STA_TENTHS : STD_HD_STA_TENTHS, US);
    localparam int T_SU_STO = t_cycles((I2C_MODE != 0) ? FST_SU_STO_TENTHS : STD_SU_STO_TENTHS, US);
    localparam int T_BUF    = t_cycles((I2C_MODE != 0) ? FST_BUF_TENTHS    : STD_BUF_TENTHS,    US);
    localparam int T_LOW    = t_cycles((I2C_MODE != 0) ? FST_LOW_TENTHS    : STD_LOW_TENTHS,    US);
    localparam int T_MAX    = max2(max2(max2(T_SU_STA, T_HD_STA), max2(T_SU_STO, T_BUF)), T_LOW);
    // floor(log2(T_MAX)) + 1 bits
    localparam int CNT_W    = $clog2(T_MAX + 1);

    // Count loaded on entry to state s.
    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        case (s)
            ST_RS_LOW:  return CNT_W'(T_LOW - 1);
            ST_STO_LOW: return CNT_W'(T_LOW - 1);
            ST_STA_SU:  return CNT_W'(T_SU_STA - 1);
            ST_STA_HD:  return CNT_W'(T_HD_STA - 1);
            ST_STO_SU:  return CNT_W'(T_SU_STO - 1);
            ST_STO_BUF: return CNT_W'(T_BUF - 1);
            default:    return '0;
        endcase
    endfunction

    state_t           state;
    state_t           nxt;
    logic             from_rs;
    logic             from_rs_nxt;
    logic             done_nxt;
    logic             arbl_nxt;
    logic             accept;
    logic             arb_hit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_exp;

    assign accept  = cmd_vld && cmd_rdy;
    // Another master pulled SDA low while SCL is high: it issued a START.
    assign arb_hit = scl_in && !sda_in;

    // STA_SU waits for a free bus only on a fresh START; a repeated START
    // already owns the bus, so there only SCL stretching pauses it.
    assign tmr_en = (state == ST_RS_LOW) || (state == ST_STA_HD) ||
                    (state == ST_STO_LOW) || (state == ST_STO_BUF) ||
                    ((state == ST_STA_SU) && scl_in && (from_rs || !bby)) ||
                    ((state == ST_STO_SU) && scl_in);

    i2c_period_timer #(
        .W        (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .enable   (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        nxt         = state;
        from_rs_nxt = from_rs;
        done_nxt    = 1'b0;
        arbl_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd == CMD_START) begin
                        nxt         = ST_STA_SU;
                        from_rs_nxt = 1'b0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (cmd == CMD_START) begin
                        nxt = ST_RS_LOW;
                    end else if (cmd == CMD_STOP) begin
                        nxt = ST_STO_LOW;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_RS_LOW: begin
                if (tmr_exp) begin
                    nxt         = ST_STA_SU;
                    from_rs_nxt = 1'b1;
                end
            end
            ST_STA_SU: begin
                if (arb_hit) begin
                    nxt      = ST_IDLE;
                    arbl_nxt = 1'b1;
                end else if (tmr_exp) begin
                    nxt = ST_STA_HD;
                end
            end
            ST_STA_HD: begin
                if (tmr_exp) begin
                    nxt      = ST_HOLD;
                    done_nxt = 1'b1;
                end
            end
            ST_STO_LOW: begin
                if (tmr_exp) nxt = ST_STO_SU;
            end
            ST_STO_SU: begin
                if (tmr_exp) nxt = ST_STO_BUF;
            end
            ST_STO_BUF: begin
                if (arb_hit) begin
                    nxt      = ST_IDLE;
                    arbl_nxt = 1'b1;
                end else if (tmr_exp) begin
                    nxt      = ST_IDLE;
                    done_nxt = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and never glitch onto the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            from_rs  <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            arbl     <= 1'b0;
            cmd_rdy  <= 1'b1;
            own      <= 1'b0;
            tmr_load <= 1'b0;
            tmr_val  <= '0;
        end else begin
            state              <= nxt;
            from_rs            <= from_rs_nxt;
            {scl_oe, sda_oe}   <= oe_of(nxt);
            done               <= done_nxt;
            arbl               <= arbl_nxt;
            cmd_rdy            <= (nxt == ST_IDLE) || (nxt == ST_HOLD);
            own                <= (nxt != ST_IDLE);
            tmr_load           <= (nxt != state);
            tmr_val            <= load_for(nxt);
        end
    end

endmodule
